logic_op_scheduler: RTL and testbench



---
 rtl/logic_op_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_logic_op_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one bitwise logic unit (AND/OR/XOR/NAND) between N_REQ requesters.
// Define LOGIC_SCHED_FIXED_PRIO_EN to replace round-robin arbitration with fixed lowest-index priority.
module logic_op_scheduler #(
   parameter  int N_REQ = 4,
   parameter  int DW    = 32,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [2*N_REQ-1:0]    req_op,
   input  logic [DW*N_REQ-1:0]   req_a,
   input  logic [DW*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]      req_ack,
   output logic                  rsp_valid,
   output logic [DW-1:0]         rsp_data,
   output logic [ID_W-1:0]       rsp_id,
   input  logic                  rsp_ready,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   win_q, win_d;
   logic [1:0]        op_q, op_d;
   logic [DW-1:0]     a_q, a_d, b_q, b_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]     rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic              busy_q, busy_d;

   logic [ID_W-1:0]   base_ptr;
   logic [ID_W:0]     cand;
   logic              grant_found;
   logic [ID_W-1:0]   grant_idx;
   logic [1:0]        grant_op;
   logic [DW-1:0]     grant_a, grant_b;
   logic [N_REQ-1:0]  grant_oh;

   function automatic logic [DW-1:0] logic_fn(input logic [1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
      case (op_t'(op))
         OP_AND:  logic_fn = a & b;
         OP_OR:   logic_fn = a | b;
         OP_XOR:  logic_fn = a ^ b;
         default: logic_fn = ~(a & b);
      endcase
   endfunction

`ifdef LOGIC_SCHED_FIXED_PRIO_EN
   assign base_ptr = '0;
`else
   logic [ID_W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == S_RESP && rsp_ready) begin
         ptr_d = (win_q == ID_W'(N_REQ - 1)) ? '0 : win_q + ID_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign base_ptr = ptr_q;
`endif

   // Scan upward from base_ptr, wrapping at N_REQ-1; the first valid index wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, base_ptr} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(N_REQ)) begin
            cand = cand - (ID_W+1)'(N_REQ);
         end
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      grant_op = '0;
      grant_a  = '0;
      grant_b  = '0;
      grant_oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            grant_op    = req_op[2*i +: 2];
            grant_a     = req_a[i*DW +: DW];
            grant_b     = req_b[i*DW +: DW];
            grant_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every _d starts from its hold value (ack from zero) so no path through the case can infer a latch.
      state_d     = state_q;
      win_d       = win_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      ack_d       = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               win_d   = grant_idx;
               op_d    = grant_op;
               a_d     = grant_a;
               b_d     = grant_b;
               ack_d   = grant_oh;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            rsp_data_d  = logic_fn(op_q, a_q, b_q);
            rsp_id_d    = win_q;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         win_q       <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         ack_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register here sample the pre-edge values of the others.
         state_q     <= state_d;
         win_q       <= win_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         ack_q       <= ack_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ack   = ack_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Self-checking bench for logic_op_scheduler: directed scenarios plus randomized transactions
// checked against a transaction-level arbitration/logic model.
module tb_logic_op_scheduler;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int IW = 2;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [2*N-1:0]    req_op;
   logic [DW*N-1:0]   req_a;
   logic [DW*N-1:0]   req_b;
   logic [N-1:0]      req_ack;
   logic              rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic [IW-1:0]     rsp_id;
   logic              rsp_ready;
   logic              busy;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int last_ack = -100;
   int m_ptr    = 0;

   logic [N-1:0]  tb_valid;
   logic [1:0]    tb_op [N];
   logic [DW-1:0] tb_a  [N];
   logic [DW-1:0] tb_b  [N];

   logic_op_scheduler #(.N_REQ(N), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ack   (req_ack),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_op(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   function automatic int exp_winner(input logic [N-1:0] v, input int p);
      int start;
`ifdef LOGIC_SCHED_FIXED_PRIO_EN
      start = 0;
`else
      start = p;
`endif
      for (int k = 0; k < N; k++) begin
         if (((v >> ((start + k) % N)) & 1) != 0) return (start + k) % N;
      end
      return -1;
   endfunction

   task automatic drive();
      req_valid = tb_valid;
      for (int i = 0; i < N; i++) begin
         req_op[2*i +: 2] = tb_op[i];
         req_a[i*DW +: DW] = tb_a[i];
         req_b[i*DW +: DW] = tb_b[i];
      end
   endtask

   // Called at a negedge with the DUT idle. mode: 0 keep operands, 1 zero winner's A after ack, 2 randomize winner's request after ack.
   task automatic run_txn(input int ready_delay, input bit keep_valid, input int mode, input bit chk_sp);
      int w;
      logic [DW-1:0] exp_d;
      if (tb_valid == '0) tb_valid = N'(1);
      w = exp_winner(tb_valid, m_ptr);
      exp_d = ref_op(tb_op[w], tb_a[w], tb_b[w]);
      rsp_ready = (ready_delay == 0);
      drive();
      @(posedge clk);
      @(negedge clk);
      check("ack", req_ack, {{(N-1){1'b0}}, 1'b1} << w);
      check("busy_exec", busy, 1);
      check("valid_exec", rsp_valid, 0);
      if (chk_sp) check("grant_spacing", cyc - last_ack, 3);
      last_ack = cyc;
      if (!keep_valid) tb_valid[w] = 1'b0;
      if (mode == 1) tb_a[w] = '0;
      if (mode == 2) begin
         tb_op[w] = 2'($urandom);
         tb_a[w]  = $urandom;
         tb_b[w]  = $urandom;
      end
      drive();
      @(negedge clk);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, exp_d);
      check("rsp_id", rsp_id, w);
      check("ack_resp", req_ack, 0);
      for (int c = 0; c < ready_delay; c++) begin
         @(negedge clk);
         check("hold_valid", rsp_valid, 1);
         check("hold_data", rsp_data, exp_d);
         check("hold_id", rsp_id, w);
         check("hold_ack", req_ack, 0);
         check("hold_busy", busy, 1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rsp_done", rsp_valid, 0);
      check("busy_idle", busy, 0);
      check("ack_idle", req_ack, 0);
      m_ptr = (w + 1) % N;
   endtask

   initial begin
      rst = 1'b0;
      rsp_ready = 1'b0;
      tb_valid = '0;
      for (int i = 0; i < N; i++) begin
         tb_op[i] = '0;
         tb_a[i]  = '0;
         tb_b[i]  = '0;
      end
      drive();
      #1 rst = 1'b1;
      #1;
      check("rst_valid", rsp_valid, 0);
      check("rst_ack", req_ack, 0);
      check("rst_busy", busy, 0);
      check("rst_data", rsp_data, 0);
      check("rst_id", rsp_id, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_ack", req_ack, 0);

      // Requester 0 AND.
      tb_op[0] = 2'd0;
      tb_a[0]  = 32'hF0F0F0F0;
      tb_b[0]  = 32'hFF00FF00;
      tb_valid = 4'b0001;
      run_txn(0, 0, 0, 0);

      // All four ops on requester 2, held valid: repeated grants at 3-cycle spacing.
      tb_a[2] = 32'h0000FFFF;
      tb_b[2] = 32'h00FF00FF;
      tb_valid = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         tb_op[2] = 2'(k);
         run_txn(0, k < 3, 0, k > 0);
      end

      // Restart the pointer, then all requesters continuously valid.
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      m_ptr = 0;
      for (int i = 0; i < N; i++) begin
         tb_op[i] = 2'($urandom);
         tb_a[i]  = $urandom;
         tb_b[i]  = $urandom;
      end
      tb_valid = 4'b1111;
      for (int k = 0; k < 5; k++) run_txn(0, 1, 0, k > 0);

      // Backpressure with every requester still waiting.
      run_txn(5, 1, 0, 0);

      // Operand change during EXEC must not reach the result.
      tb_valid = 4'b0001;
      tb_op[0] = 2'd2;
      tb_a[0]  = 32'hF0F0F0F0;
      tb_b[0]  = 32'hFF00FF00;
      run_txn(1, 0, 1, 0);

      // Leave the pointer at 2, then reset while a response is pending.
      tb_valid = 4'b0010;
      run_txn(0, 0, 0, 0);
      tb_valid = 4'b0010;
      rsp_ready = 1'b0;
      drive();
      @(posedge clk);
      @(negedge clk);
      check("mid_ack", req_ack, 4'b0010);
      tb_valid = '0;
      drive();
      @(negedge clk);
      check("mid_valid", rsp_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("async_valid", rsp_valid, 0);
      check("async_ack", req_ack, 0);
      check("async_busy", busy, 0);
      check("async_data", rsp_data, 0);
      @(negedge clk) rst = 1'b0;
      m_ptr = 0;
      @(negedge clk);
      check("dropped_valid", rsp_valid, 0);
      check("dropped_busy", busy, 0);
      tb_valid = 4'b1010;
      run_txn(0, 0, 0, 0);
      tb_valid = 4'b1000;
      run_txn(0, 0, 0, 0);

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         if (tb_valid == '0) begin
            tb_valid = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
               tb_op[i] = 2'($urandom);
               tb_a[i]  = $urandom;
               tb_b[i]  = $urandom;
            end
         end
         run_txn($urandom_range(0, 2), 1'($urandom), 2, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
